serial_compare_ctrl: RTL and testbench
======================================

Name: serial_compare_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands by scanning them MSB-first, one 2-bit slice per clock, with a start/busy/done handshake.
- Reuses a single 2-bit magnitude-compare slice for operands of any even width, so the comparator datapath stays 2 bits wide.
- Sits between a requesting controller and the comparator slice. It latches the operands, steps the slice index, and stops early on the first unequal slice.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2; NSLICE = WIDTH/2.
- EARLY_EXIT, 1, 1 = stop on first unequal slice; 0 = always scan all NSLICE slices (constant latency).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request pulse; accepted only in IDLE.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- gt  output  1  A > B (registered, held until next accept).
- eq  output  1  A == B (registered, held).
- lt  output  1  A < B (registered, held).
- slices  output  $clog2(NSLICE+1)  number of slices examined for the last result.

Behaviour:
- Reset: clk and rst_n only; rst_n=0 at any edge forces IDLE. It also clears busy, done, gt, eq, lt, slices, the index and the operand registers to 0. This applies mid-RUN: the operation is aborted and no done is issued.
- States:
  - IDLE: start=1 latches a and b into areg and breg, sets idx=NSLICE-1, slices=0, and clears gt/eq/lt. Next state is RUN; busy=1 from this edge.
  - RUN: each cycle the block compares slice s_a=areg[2*idx+1:2*idx] against s_b=breg[2*idx+1:2*idx].
    - Unequal slice and EARLY_EXIT=1: set gt=(s_a>s_b), lt=(s_a<s_b), eq=0. Go to DONE.
    - Unequal slice and EARLY_EXIT=0: record the first-unequal result in a sticky flag. Continue scanning.
    - Equal slice with idx==0: finish with eq=1 if no sticky flag, otherwise the sticky gt/lt. Go to DONE.
    - Equal slice with idx>0: idx decrements and the scan continues.
    - slices increments every RUN cycle.
  - DONE: done=1 and busy=0 for exactly one cycle. Next state is IDLE unconditionally.
- Latency, counted in edges from the accepting edge to the edge that asserts done:
  - Equal operands, or EARLY_EXIT=0: NSLICE edges.
  - First mismatch at slice k (MSB slice = NSLICE-1): NSLICE-k edges.
- Result invariant: exactly one of gt/eq/lt is 1 after any completed operation. All three are 0 after reset and while RUN is in progress.
- start handling:
  - start in RUN or DONE is ignored; the request is not queued.
  - start held high is accepted again on the first IDLE cycle after DONE.
  - a and b changing during RUN have no effect.
- Back-to-back throughput: one operation per NSLICE+2 cycles at most (accept, RUN cycles, DONE, then back to IDLE).
- WIDTH=2: NSLICE=1 and every operation takes one RUN cycle.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, keep start=0 -> busy=done=gt=eq=lt=0 and slices=0 for 5 cycles.
- Equal, WIDTH=8: a=8'hA5, b=8'hA5, start pulse -> busy for 4 cycles. done pulses 4 edges after accept with eq=1, gt=lt=0 and slices=4.
- Early MSB mismatch: a=8'hC0, b=8'h3F -> done 1 edge after accept with gt=1 and slices=1. Then a=8'h01, b=8'h02 -> done 4 edges after accept with lt=1 and slices=4.
- EARLY_EXIT=0: a=8'h80, b=8'h7F -> done 4 edges after accept with gt=1 and slices=4, even though the mismatch is in the first slice.
- Ignored start and operand change: re-pulse start and change a/b to 8'hFF/8'h00 during RUN of a=8'h10, b=8'h20 -> single done with lt=1. No second operation starts unless start is present in IDLE.
- Reset mid-operation: assert rst_n=0 on the 2nd RUN cycle of an equal compare -> next cycle IDLE with all outputs 0 and no done pulse. A subsequent compare of 8'h03 vs 8'h02 gives gt=1.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// rtl/serial_compare_ctrl.sv - MSB-first serial magnitude comparator built on one 2-bit slice
module serial_compare_ctrl #(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   output logic                         busy,
   output logic                         done,
   output logic                         gt,
   output logic                         eq,
   output logic                         lt,
   output logic [$clog2(WIDTH/2+1)-1:0] slices
);

   localparam int NSLICE = WIDTH / 2;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int SW     = $clog2(NSLICE + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDXW-1:0]  r_idx;
   logic [SW-1:0]    r_slices;
   logic             r_busy;
   logic             r_done;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;
   // first-unequal slice result, only used when the full width is always scanned
   logic             r_sticky;
   logic             r_sgt;

   logic [1:0]       w_sa;
   logic [1:0]       w_sb;
   logic             w_ne;
   logic             w_gt;

   // select the 2-bit slice pair addressed by the current index
   always_comb begin
      w_sa = 2'b00;
      w_sb = 2'b00;
      for (int i = 0; i < NSLICE; i++) begin
         if (r_idx == IDXW'(i)) begin
            w_sa = r_a[2*i +: 2];
            w_sb = r_b[2*i +: 2];
         end
      end
   end

   assign w_ne = (w_sa != w_sb);
   assign w_gt = (w_sa > w_sb);

   // sequencer: accept, scan slices MSB-first, pulse done, return to idle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_idx    <= '0;
         r_slices <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_gt     <= 1'b0;
         r_eq     <= 1'b0;
         r_lt     <= 1'b0;
         r_sticky <= 1'b0;
         r_sgt    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_idx    <= IDXW'(NSLICE - 1);
                  r_slices <= '0;
                  r_gt     <= 1'b0;
                  r_eq     <= 1'b0;
                  r_lt     <= 1'b0;
                  r_sticky <= 1'b0;
                  r_sgt    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_slices <= r_slices + 1'b1;
               if (w_ne && EARLY_EXIT) begin
                  r_gt    <= w_gt;
                  r_lt    <= ~w_gt;
                  r_eq    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_idx == '0) begin
                  // last slice: the earliest mismatch seen decides the result
                  if (r_sticky) begin
                     r_gt <= r_sgt;
                     r_lt <= ~r_sgt;
                  end else if (w_ne) begin
                     r_gt <= w_gt;
                     r_lt <= ~w_gt;
                  end else begin
                     r_eq <= 1'b1;
                  end
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  if (w_ne && !r_sticky) begin
                     r_sticky <= 1'b1;
                     r_sgt    <= w_gt;
                  end
                  r_idx <= r_idx - 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign gt     = r_gt;
   assign eq     = r_eq;
   assign lt     = r_lt;
   assign slices = r_slices;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb/tb_serial_compare_ctrl.sv - scoreboard bench for serial_compare_ctrl, early-exit and full-scan
module tb_serial_compare_ctrl;

   localparam int NSLICE = 4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a_i;
   logic [7:0] b_i;

   logic       busy_e, done_e, gt_e, eq_e, lt_e;
   logic [2:0] sl_e;
   logic       busy_f, done_f, gt_f, eq_f, lt_f;
   logic [2:0] sl_f;

   typedef struct {
      logic   gt;
      logic   eq;
      logic   lt;
      int     sl;
      longint done_cyc;
   } exp_t;

   exp_t   q_e[$];
   exp_t   q_f[$];
   int     n_pass    = 0;
   int     n_total   = 0;
   int     n_timeout = 0;
   longint cyc       = 0;
   bit     chk_idle  = 1'b0;
   bit     end_req   = 1'b0;
   bit     finished  = 1'b0;

   serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i),
      .busy(busy_e), .done(done_e), .gt(gt_e), .eq(eq_e), .lt(lt_e), .slices(sl_e)
   );

   serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i),
      .busy(busy_f), .done(done_f), .gt(gt_f), .eq(eq_f), .lt(lt_f), .slices(sl_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // reference: latency equals slices examined; early exit stops at the highest differing bit's slice
   function automatic int ref_slices(input logic [7:0] x, input logic [7:0] y, input bit ee);
      logic [7:0] d;
      d = x ^ y;
      if (!ee || d == 8'h00) return NSLICE;
      for (int i = 7; i >= 0; i--) begin
         if (d[i]) return NSLICE - i / 2;
      end
      return NSLICE;
   endfunction

   function automatic exp_t make_exp(input logic [7:0] x, input logic [7:0] y, input bit ee,
                                     input longint base);
      exp_t e;
      e.gt       = (x > y);
      e.eq       = (x == y);
      e.lt       = (x < y);
      e.sl       = ref_slices(x, y, ee);
      e.done_cyc = base + e.sl;
      return e;
   endfunction

   task automatic chk(input string nm, input longint act, input longint expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
   endtask

   task automatic check_done(input bit is_e, input logic g, input logic e, input logic l,
                             input logic [2:0] s);
      exp_t  x;
      string p;
      p = is_e ? "ee" : "full";
      if ((is_e && q_e.size() == 0) || (!is_e && q_f.size() == 0)) begin
         n_total++;
         $display("FAIL spurious_done_%s: got done=1 expected no pending operation (cycle %0d)",
                  p, cyc);
         return;
      end
      if (is_e) x = q_e.pop_front();
      else      x = q_f.pop_front();
      chk({"result_", p}, {g, e, l}, {x.gt, x.eq, x.lt});
      chk({"slices_", p}, s, x.sl);
      chk({"latency_", p}, cyc, x.done_cyc);
   endtask

   // monitor: compares every done pulse against the scoreboard and checks flag invariants
   always @(negedge clk) begin
      if (chk_idle) begin
         chk("idle_ee", {busy_e, done_e, gt_e, eq_e, lt_e, sl_e}, 0);
         chk("idle_full", {busy_f, done_f, gt_f, eq_f, lt_f, sl_f}, 0);
      end
      if (rst_n && !finished) begin
         if (done_e) check_done(1'b1, gt_e, eq_e, lt_e, sl_e);
         if (done_f) check_done(1'b0, gt_f, eq_f, lt_f, sl_f);
         if (busy_e) chk("run_flags_ee", {gt_e, eq_e, lt_e}, 0);
         if (busy_f) chk("run_flags_full", {gt_f, eq_f, lt_f}, 0);
      end
      if (end_req && !finished) begin
         finished = 1'b1;
         chk("pending_ee", q_e.size(), 0);
         chk("pending_full", q_f.size(), 0);
         chk("timeouts", n_timeout, 0);
         $display("%0d/%0d checks passed", n_pass, n_total);
         $finish;
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy_e || done_e || busy_f || done_f) begin
         @(negedge clk);
         n++;
         if (n > 40) begin
            n_timeout++;
            return;
         end
      end
   endtask

   task automatic push_op(input logic [7:0] x, input logic [7:0] y, input longint base);
      q_e.push_back(make_exp(x, y, 1'b1, base));
      q_f.push_back(make_exp(x, y, 1'b0, base));
   endtask

   task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit poke);
      wait_idle();
      a_i   = x;
      b_i   = y;
      start = 1'b1;
      push_op(x, y, cyc + 1);
      @(negedge clk);
      start = 1'b0;
      a_i   = 8'($urandom);
      b_i   = 8'($urandom);
      if (poke) begin
         start = 1'b1;
         a_i   = 8'hFF;
         b_i   = 8'h00;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle();
   endtask

   initial begin
      exp_t       e1;
      exp_t       f1;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] m;
      rst_n = 1'b0;
      start = 1'b0;
      a_i   = 8'h00;
      b_i   = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk_idle = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk_idle = 1'b0;
      @(negedge clk);

      do_op(8'hA5, 8'hA5, 1'b0);
      do_op(8'hC0, 8'h3F, 1'b0);
      do_op(8'h01, 8'h02, 1'b0);
      do_op(8'h80, 8'h7F, 1'b0);
      do_op(8'h10, 8'h20, 1'b1);

      // start held high: re-accepted on the first idle cycle after done
      wait_idle();
      a_i   = 8'h5A;
      b_i   = 8'h5A;
      start = 1'b1;
      e1 = make_exp(8'h5A, 8'h5A, 1'b1, cyc + 1);
      f1 = make_exp(8'h5A, 8'h5A, 1'b0, cyc + 1);
      q_e.push_back(e1);
      q_e.push_back(make_exp(8'h5A, 8'h5A, 1'b1, e1.done_cyc + 2));
      q_f.push_back(f1);
      q_f.push_back(make_exp(8'h5A, 8'h5A, 1'b0, f1.done_cyc + 2));
      repeat (7) @(negedge clk);
      start = 1'b0;
      wait_idle();

      // reset sampled at the end of the second run cycle aborts without done
      wait_idle();
      a_i   = 8'hA5;
      b_i   = 8'hA5;
      start = 1'b1;
      push_op(8'hA5, 8'hA5, cyc + 1);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      q_e.delete();
      q_f.delete();
      @(posedge clk);
      #1 chk_idle = 1'b1;
      @(posedge clk);
      #1 chk_idle = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      do_op(8'h03, 8'h02, 1'b0);

      for (int n = 0; n < 150; n++) begin
         x = 8'($urandom);
         case ($urandom_range(0, 2))
            0: y = 8'($urandom);
            1: y = x;
            default: begin
               m = 8'h03 << (2 * $urandom_range(0, 3));
               y = x ^ (m & 8'($urandom_range(1, 255)));
            end
         endcase
         do_op(x, y, $urandom_range(0, 3) == 0);
      end

      repeat (3) @(negedge clk);
      end_req = 1'b1;
   end

endmodule
